io_bus_arbiter: RTL and testbench

- Shares one memory-mapped io_interface port (waddr/raddr/wdata/rdata/wenable) between two requesters: m0 is the CPU datapath load/store path, m1 is the debug/DMA poker.
- Sits between the datapath and a device driver such as vga_driver or the hex driver.
- Arbitrates round-robin, issues one transaction per grant, and sequences fixed-latency reads back to the owning requester.

---
 rtl/io_bus_arbiter_if.sv | 46 ++++
 rtl/io_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
// Bundles the two requester ports and the shared device port of io_bus_arbiter.
// master = arbiter side; slave = requesters plus device.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] io_waddr;
    logic [ADDR_W-1:0] io_raddr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_wenable;
    logic [DATA_W-1:0] io_rdata;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output io_waddr, io_raddr, io_wdata, io_wenable,
        input  io_rdata
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  io_waddr, io_raddr, io_wdata, io_wenable,
        output io_rdata
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter for one memory-mapped io port with fixed-latency reads.
// Define IO_ARB_PRIORITY_EN to give m0 strict priority over m1.
module io_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    io_bus_arbiter_if.master bus
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              rd_owner_q, rd_owner_d;
    logic              m0_gnt_q, m0_gnt_d;
    logic              m1_gnt_q, m1_gnt_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic [ADDR_W-1:0] io_waddr_q, io_waddr_d;
    logic [ADDR_W-1:0] io_raddr_q, io_raddr_d;
    logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
    logic              io_wenable_q, io_wenable_d;

    logic              m0_elig_s;
    logic              m1_elig_s;
    logic              pick_m1_s;
    logic              rd_done_s;
    logic              grant_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Winner selection; a master is deaf during its own grant cycle.
    always_comb begin
        m0_elig_s = bus.m0_req && !m0_gnt_q;
        m1_elig_s = bus.m1_req && !m1_gnt_q;
`ifdef IO_ARB_PRIORITY_EN
        pick_m1_s = !m0_elig_s;
`else
        if (m0_elig_s && m1_elig_s) begin
            pick_m1_s = !last_q;
        end else begin
            pick_m1_s = !m0_elig_s;
        end
`endif
        // The completing read edge may also launch the next grant.
        rd_done_s   = (state_q == READ_WAIT) && (cnt_q == CNT_ZERO);
        grant_s     = ((state_q == IDLE) || rd_done_s) && (m0_elig_s || m1_elig_s);
        sel_we_s    = pick_m1_s ? bus.m1_we    : bus.m0_we;
        sel_addr_s  = pick_m1_s ? bus.m1_addr  : bus.m0_addr;
        sel_wdata_s = pick_m1_s ? bus.m1_wdata : bus.m0_wdata;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        rd_owner_d   = rd_owner_q;
        m0_gnt_d     = 1'b0;
        m1_gnt_d     = 1'b0;
        m0_rvalid_d  = 1'b0;
        m1_rvalid_d  = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        io_waddr_d   = io_waddr_q;
        io_raddr_d   = io_raddr_q;
        io_wdata_d   = io_wdata_q;
        io_wenable_d = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            READ_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                    if (rd_owner_q) begin
                        m1_rvalid_d = 1'b1;
                        m1_rdata_d  = bus.io_rdata;
                    end else begin
                        m0_rvalid_d = 1'b1;
                        m0_rdata_d  = bus.io_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_s) begin
            last_d     = pick_m1_s;
            io_waddr_d = sel_addr_s;
            io_raddr_d = sel_addr_s;
            io_wdata_d = sel_wdata_s;
            if (pick_m1_s) begin
                m1_gnt_d = 1'b1;
            end else begin
                m0_gnt_d = 1'b1;
            end
            if (sel_we_s) begin
                io_wenable_d = 1'b1;
            end else begin
                // State is READ_WAIT from the grant cycle on so no grant lands before the data.
                state_d    = READ_WAIT;
                cnt_d      = LAT_LOAD;
                rd_owner_d = pick_m1_s;
            end
        end else begin
            last_d = last_q;
        end
    end

    // State and output registers; reset aborts any read in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            last_q       <= 1'b1;
            rd_owner_q   <= 1'b0;
            m0_gnt_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m0_rdata_q   <= {DATA_W{1'b0}};
            m1_rdata_q   <= {DATA_W{1'b0}};
            io_waddr_q   <= {ADDR_W{1'b0}};
            io_raddr_q   <= {ADDR_W{1'b0}};
            io_wdata_q   <= {DATA_W{1'b0}};
            io_wenable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            rd_owner_q   <= rd_owner_d;
            m0_gnt_q     <= m0_gnt_d;
            m1_gnt_q     <= m1_gnt_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_rvalid_q  <= m1_rvalid_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            io_waddr_q   <= io_waddr_d;
            io_raddr_q   <= io_raddr_d;
            io_wdata_q   <= io_wdata_d;
            io_wenable_q <= io_wenable_d;
        end
    end

    assign bus.m0_gnt     = m0_gnt_q;
    assign bus.m1_gnt     = m1_gnt_q;
    assign bus.m0_rvalid  = m0_rvalid_q;
    assign bus.m1_rvalid  = m1_rvalid_q;
    assign bus.m0_rdata   = m0_rdata_q;
    assign bus.m1_rdata   = m1_rdata_q;
    assign bus.io_waddr   = io_waddr_q;
    assign bus.io_raddr   = io_raddr_q;
    assign bus.io_wdata   = io_wdata_q;
    assign bus.io_wenable = io_wenable_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter with RD_LATENCY=3.
module tb_io_bus_arbiter;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic exp_first;

    io_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    io_bus_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .RD_LATENCY(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 16'h0000; bus.m0_wdata = 16'h0000;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 16'h0000; bus.m1_wdata = 16'h0000;
        bus.io_rdata = 16'hDEAD;

        // Reset state
        #2;
        chk("rst_m0_gnt",    32'(bus.m0_gnt),     32'd0);
        chk("rst_m1_gnt",    32'(bus.m1_gnt),     32'd0);
        chk("rst_m0_rvalid", 32'(bus.m0_rvalid),  32'd0);
        chk("rst_m1_rvalid", 32'(bus.m1_rvalid),  32'd0);
        chk("rst_wenable",   32'(bus.io_wenable), 32'd0);
        chk("rst_waddr",     32'(bus.io_waddr),   32'd0);
        chk("rst_raddr",     32'(bus.io_raddr),   32'd0);
        chk("rst_wdata",     32'(bus.io_wdata),   32'd0);
        chk("rst_m0_rdata",  32'(bus.m0_rdata),   32'd0);
        chk("rst_m1_rdata",  32'(bus.m1_rdata),   32'd0);
        @(negedge clock) reset = 1'b1;
        cyc();

        // Single write from m0
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 16'h0010; bus.m0_wdata = 16'hBEEF;
        cyc();
        chk("wr_m0_gnt",  32'(bus.m0_gnt),     32'd1);
        chk("wr_m1_gnt",  32'(bus.m1_gnt),     32'd0);
        chk("wr_wenable", 32'(bus.io_wenable), 32'd1);
        chk("wr_waddr",   32'(bus.io_waddr),   32'h0010);
        chk("wr_wdata",   32'(bus.io_wdata),   32'hBEEF);
        bus.m0_req = 1'b0;
        cyc();
        chk("wr_wenable_off", 32'(bus.io_wenable), 32'd0);
        chk("wr_gnt_off",     32'(bus.m0_gnt),     32'd0);
        chk("wr_waddr_hold",  32'(bus.io_waddr),   32'h0010);

        // m1 read with latency 3, m0 blocked while waiting
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0020; bus.m1_wdata = 16'h0000;
        cyc();
        chk("rd_m1_gnt",   32'(bus.m1_gnt),     32'd1);
        chk("rd_raddr",    32'(bus.io_raddr),   32'h0020);
        chk("rd_wenable",  32'(bus.io_wenable), 32'd0);
        bus.m1_req = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 16'h0030; bus.m0_wdata = 16'h5555;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("rd_wait%0d_m0_gnt", k),    32'(bus.m0_gnt),    32'd0);
            chk($sformatf("rd_wait%0d_m1_rvalid", k), 32'(bus.m1_rvalid), 32'd0);
            chk($sformatf("rd_wait%0d_raddr", k),     32'(bus.io_raddr),  32'h0020);
            if (k == 3) bus.io_rdata = 16'h1234;
        end
        cyc();
        chk("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
        chk("rd_m1_rdata",  32'(bus.m1_rdata),  32'h1234);
        chk("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
        chk("rd_m0_gnt",    32'(bus.m0_gnt),    32'd1);
        chk("rd_m0_waddr",  32'(bus.io_waddr),  32'h0030);
        bus.io_rdata = 16'hDEAD;
        bus.m0_req = 1'b0;
        cyc();
        chk("rd_rvalid_off",  32'(bus.m1_rvalid), 32'd0);
        chk("rd_rdata_hold",  32'(bus.m1_rdata),  32'h1234);
        chk("rd_m0_gnt_off",  32'(bus.m0_gnt),    32'd0);

        // m0 streaming: one grant every other cycle
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 16'h0050; bus.m0_wdata = 16'h1111;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk($sformatf("stream%0d_m0_gnt", i),  32'(bus.m0_gnt),     ((i % 2 == 1) && (i <= 7)) ? 32'd1 : 32'd0);
            chk($sformatf("stream%0d_wenable", i), 32'(bus.io_wenable), ((i % 2 == 1) && (i <= 7)) ? 32'd1 : 32'd0);
            if (i == 7) bus.m0_req = 1'b0;
        end

        // Tie right after an m0-only grant: pointer decides unless m0 has priority
`ifdef IO_ARB_PRIORITY_EN
        exp_first = 1'b0;
`else
        exp_first = 1'b1;
`endif
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 16'h0070; bus.m0_wdata = 16'h7070;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 16'h0071; bus.m1_wdata = 16'h7171;
        cyc();
        chk("tie_m0_gnt", 32'(bus.m0_gnt),   32'(!exp_first));
        chk("tie_m1_gnt", 32'(bus.m1_gnt),   32'(exp_first));
        chk("tie_waddr",  32'(bus.io_waddr), exp_first ? 32'h0071 : 32'h0070);
        if (exp_first) bus.m1_req = 1'b0; else bus.m0_req = 1'b0;
        cyc();
        chk("tie2_m0_gnt", 32'(bus.m0_gnt),   32'(exp_first));
        chk("tie2_m1_gnt", 32'(bus.m1_gnt),   32'(!exp_first));
        chk("tie2_waddr",  32'(bus.io_waddr), exp_first ? 32'h0070 : 32'h0071);
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        cyc();
        chk("tie3_gnt_off", 32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);

        // Reset during READ_WAIT
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0060;
        cyc();
        chk("rr_m1_gnt", 32'(bus.m1_gnt),   32'd1);
        chk("rr_raddr",  32'(bus.io_raddr), 32'h0060);
        bus.m1_req = 1'b0;
        cyc();
        #2 reset = 1'b0;
        #1;
        chk("rr_async_raddr",   32'(bus.io_raddr),   32'd0);
        chk("rr_async_waddr",   32'(bus.io_waddr),   32'd0);
        chk("rr_async_wdata",   32'(bus.io_wdata),   32'd0);
        chk("rr_async_m1_rdata", 32'(bus.m1_rdata),  32'd0);
        chk("rr_async_wenable", 32'(bus.io_wenable), 32'd0);
        bus.io_rdata = 16'h7777;
        @(negedge clock) reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("rr_post%0d_m1_rvalid", i), 32'(bus.m1_rvalid), 32'd0);
            chk($sformatf("rr_post%0d_m0_rvalid", i), 32'(bus.m0_rvalid), 32'd0);
        end
        chk("rr_post_m1_rdata", 32'(bus.m1_rdata), 32'd0);

        // Continuous contention after reset: m0 first, then alternation
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 16'h0040; bus.m0_wdata = 16'h0A0A;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 16'h0041; bus.m1_wdata = 16'h0B0B;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("cont%0d_m0_gnt", i),  32'(bus.m0_gnt),     (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_m1_gnt", i),  32'(bus.m1_gnt),     (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_waddr", i),   32'(bus.io_waddr),   (i % 2 == 1) ? 32'h0040 : 32'h0041);
            chk($sformatf("cont%0d_wdata", i),   32'(bus.io_wdata),   (i % 2 == 1) ? 32'h0A0A : 32'h0B0B);
            chk($sformatf("cont%0d_wenable", i), 32'(bus.io_wenable), 32'd1);
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        cyc();
        cyc();
        chk("cont_end_gnt",     32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
        chk("cont_end_wenable", 32'(bus.io_wenable),           32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
